pl_risc_uart_tx: RTL and testbench
==================================

# pl_risc_uart_tx

Byte-wide output-port consumer for the pipelined RISC core. It captures each byte the core writes to `out_port` into a small FIFO, then serialises the bytes onto a single UART line (8N1, LSB first). It sits directly downstream of `PL_RISC_TL` at the top level, so the core never stalls on a slow serial link unless the FIFO fills.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: `clk_f` cycles per serial bit. Minimum 2.
- `FIFO_DEPTH`, 4: byte entries. Must be a power of two, minimum 2.

Ports:
- `clk_f`, in, 1: single clock.
- `rst_n`, in, 1: reset, **asynchronous, active-high**. The name is retained from the core; 1 = reset asserted.
- `out_port`, in, 8: byte from the core's output port.
- `out_we`, in, 1: write strobe, one cycle per OUT instruction.
- `tx`, out, 1: serial line; idle high.
- `busy`, out, 1: a frame is in progress.
- `empty`, out, 1: FIFO holds 0 bytes.
- `full`, out, 1: FIFO holds `FIFO_DEPTH` bytes.
- `overflow`, out, 1: sticky; set when a write is dropped. Cleared only by reset.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0. Reset also empties the FIFO, sets the FSM to IDLE and clears all counters.
- **FIFO push:**
  - On an edge where `out_we`=1 and `full`=0, write `out_port` at the write pointer.
  - If `out_we`=1 and `full`=1, drop the byte and set `overflow`. This applies even if a pop happens on the same edge.
- **FIFO pop:** the FSM pops when it leaves IDLE or STOP with the FIFO non-empty.
- **Simultaneous push and pop (not full):** count is unchanged and both pointers advance.
- **Pointers:** wrap modulo `FIFO_DEPTH`.
- **Flags:** `empty` and `full` are registered, derived from the count.
- **FSM states:**
  - IDLE: `tx`=1, `busy`=0. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0]. After each `CLKS_PER_BIT` cycles, shift right and increment the bit counter (3 bits). After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- **`busy`:** 1 in START, DATA and STOP.
- **Counters:**
  - Baud counter width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state or bit change.
  - Bit counter wraps 7→0 on the DATA→STOP transition.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronously), the frame is abandoned and queued bytes are lost.

## Timing
- **`tx` is registered:** it changes only on `clk_f` rising edges, or asynchronously on reset.
- **Write-to-start latency:** with `out_we` sampled at edge k into an empty FIFO and the FSM in IDLE:
  - edge k: `empty` falls.
  - edge k+1: pop; FSM enters START, `tx` falls and `busy` rises. `empty` returns to 1 at k+1 if no other write occurred.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles from `tx` falling to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **`full` timing:** asserts on the edge that stores the `FIFO_DEPTH`th byte. It deasserts on the edge of the next pop.

## Structure
- **Shared package `pl_risc_pkg`:**
  - FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - UART frame constants: 8 data bits, 1 stop bit.
  - Idle line level = 1.
- **Sub-module `pl_risc_sync_fifo`:**
  - Parameterised by width and depth.
  - Push/pop interface with registered `empty` and `full`.
  - Drop-on-full behaviour and the overflow pulse output.
- **Top level `pl_risc_uart_tx`:** contains the FSM, baud and bit counters, shift register and the sticky `overflow` register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. Reset held for 3 cycles, then released, with no writes → `tx`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0 for 100 cycles.
2. Single write of 8'hA5 → `tx` falls one edge later. Sampled mid-bit, the line reads 0,1,0,1,0,0,1,0,1,1: start, LSB-first data, stop. Total frame is 40 cycles, then `busy`=0.
3. Writes of 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames with no idle cycle between them. `empty` rises during the third frame's START.
4. Six consecutive writes of 8'h10..8'h15 while idle:
   - The first byte pops immediately, so 8'h10..8'h14 are accepted.
   - 8'h15 arrives with `full`=1 and is dropped; `overflow` becomes 1 and stays 1.
   - Bytes 10..14 are transmitted in order.
5. Write at full on the same edge that a STOP→START pop occurs → the byte is still dropped, `overflow`=1 and count decrements by 1.
6. Reset asserted mid-DATA of 8'hFF → `tx`=1 within the same cycle (asynchronous). After release, `empty`=1 and no further frames are sent.

Source files
------------

// File: rtl/pl_risc_pkg.sv
// Shared constants for the RISC core peripherals: UART transmitter state
// encoding and frame format.
package pl_risc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int   DATA_BITS = 8;
    localparam int   STOP_BITS = 1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/pl_risc_sync_fifo.sv
// Single-clock FIFO with registered empty/full flags; writes arriving while
// full are discarded and flagged by a one-cycle drop indication.
module pl_risc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // The drop decision uses the registered full flag, so a pop on the same
    // edge does not rescue the write.
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign drop     = push & full;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (!do_push && do_pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pl_risc_uart_tx.sv
// Output-port consumer for the pipelined RISC core: buffers OUT bytes and
// sends them as 8N1 UART frames, LSB first, with back-to-back frames.
module pl_risc_uart_tx
    import pl_risc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_f,
    input  logic       rst_n,
    input  logic [7:0] out_port,
    input  logic       out_we,
    output logic       tx,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic [1:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 baud_last;
    logic                 pop;
    logic                 drop;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign busy      = (state != ST_IDLE);
    assign pop       = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_last));

    pl_risc_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_f),
        .rst       (rst_n),
        .push      (out_we),
        .push_data (out_port),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (empty),
        .full      (full),
        .drop      (drop)
    );

    always_ff @(posedge clk_f or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= LINE_IDLE;
            overflow <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        state    <= ST_DATA;
                        baud_cnt <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= ST_STOP;
                            bit_cnt <= '0;
                            tx      <= LINE_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift register holds payload only; it is reloaded on every pop.
    always_ff @(posedge clk_f) begin
        if (pop)
            shift <= fifo_data;
        else if ((state == ST_DATA) && baud_last)
            shift <= shift >> 1;
    end

endmodule

// File: tb/tb_pl_risc_uart_tx.sv
// Directed bench for pl_risc_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a line
// monitor decodes frames mid-bit while the scenario tasks check results.
module tb_pl_risc_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk_f    = 1'b0;
    logic       rst_n    = 1'b1;
    logic [7:0] out_port = 8'h00;
    logic       out_we   = 1'b0;
    logic       tx, busy, empty, full, overflow;

    int vectors     = 0;
    int miscompares = 0;

    int         cyc     = 0;
    int         mon_cyc = -1;
    logic [9:0] mon_bits = '0;
    logic [9:0] frame_q[$];
    int         start_q[$];

    pl_risc_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_f    (clk_f),
        .rst_n    (rst_n),
        .out_port (out_port),
        .out_we   (out_we),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk_f = ~clk_f;

    // Line decoder: frame cycle 0 is the first falling clock edge with tx low;
    // bit i is sampled at frame cycle 4*i+2.
    always @(negedge clk_f) begin
        cyc++;
        if (rst_n) begin
            mon_cyc = -1;
        end else begin
            if (mon_cyc >= 0)
                mon_cyc++;
            else if (tx === 1'b0) begin
                mon_cyc = 0;
                start_q.push_back(cyc);
            end
            if (mon_cyc >= 0 && (mon_cyc % CPB) == 2)
                mon_bits[mon_cyc / CPB] = tx;
            if (mon_cyc == 10 * CPB - 2) begin
                frame_q.push_back(mon_bits);
                mon_cyc = -1;
            end
        end
    end

    task automatic step();
        @(negedge clk_f);
        #1;
    endtask

    task automatic apply_reset();
        out_we = 1'b0;
        rst_n  = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        frame_q.delete();
        start_q.delete();
    endtask

    task automatic wait_frames(input int n, input int limit);
        for (int i = 0; i < limit && frame_q.size() < n; i++)
            step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) begin
            step();
            vectors++;
            if ({tx, busy, empty, full, overflow} !== 5'b10100) begin
                miscompares++;
                $display("FAIL reset_held flags got=%b want=10100", {tx, busy, empty, full, overflow});
            end
        end
        rst_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            vectors++;
            if ({tx, busy, empty, full, overflow} !== 5'b10100) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d flags got=%b want=10100", i, {tx, busy, empty, full, overflow});
            end
        end
        vectors++;
        if (start_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_no_frames got=%0d want=0", start_q.size());
        end
    endtask

    task automatic test_single();
        int         t0;
        logic [9:0] got;
        int         lat;
        apply_reset();
        out_port = 8'hA5;
        out_we   = 1'b1;
        step();
        out_we = 1'b0;
        t0 = cyc;
        vectors++;
        if ({tx, busy, empty} !== 3'b100) begin
            miscompares++;
            $display("FAIL single_after_write tx/busy/empty got=%b want=100", {tx, busy, empty});
        end
        step();
        vectors++;
        if ({tx, busy, empty} !== 3'b011) begin
            miscompares++;
            $display("FAIL single_start_edge tx/busy/empty got=%b want=011", {tx, busy, empty});
        end
        wait_frames(1, 60);
        got = (frame_q.size() > 0) ? frame_q[0] : 10'bx;
        vectors++;
        if (got !== {1'b1, 8'hA5, 1'b0}) begin
            miscompares++;
            $display("FAIL single_frame got=%b want=%b", got, {1'b1, 8'hA5, 1'b0});
        end
        lat = (start_q.size() > 0) ? start_q[0] - t0 : -1;
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL single_latency got=%0d want=1", lat);
        end
        step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_last_stop_cycle busy got=%b want=1", busy);
        end
        step();
        vectors++;
        if ({busy, tx} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_frame_end busy/tx got=%b want=01", {busy, tx});
        end
    endtask

    task automatic test_back_to_back();
        bit         seen2 = 0;
        bit         seen3 = 0;
        logic [9:0] got;
        int         gap;
        apply_reset();
        out_we   = 1'b1;
        out_port = 8'h01;
        step();
        out_port = 8'h02;
        step();
        out_port = 8'h03;
        step();
        out_we = 1'b0;
        for (int i = 0; i < 200 && frame_q.size() < 3; i++) begin
            step();
            if (start_q.size() == 2 && !seen2) begin
                seen2 = 1;
                vectors++;
                if (empty !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_empty_frame2 got=%b want=0", empty);
                end
            end
            if (start_q.size() == 3 && !seen3) begin
                seen3 = 1;
                vectors++;
                if (empty !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_empty_frame3 got=%b want=1", empty);
                end
            end
        end
        vectors++;
        if (!seen3) begin
            miscompares++;
            $display("FAIL b2b_frame3_start got=%0d starts want=3", start_q.size());
        end
        for (int j = 0; j < 3; j++) begin
            got = (frame_q.size() > j) ? frame_q[j] : 10'bx;
            vectors++;
            if (got !== {1'b1, 8'(j + 1), 1'b0}) begin
                miscompares++;
                $display("FAIL b2b_frame%0d got=%b want=%b", j, got, {1'b1, 8'(j + 1), 1'b0});
            end
        end
        for (int j = 1; j < 3; j++) begin
            gap = (start_q.size() > j) ? start_q[j] - start_q[j-1] : -1;
            vectors++;
            if (gap != 10 * CPB) begin
                miscompares++;
                $display("FAIL b2b_gap%0d got=%0d want=%0d", j, gap, 10 * CPB);
            end
        end
        repeat (3) step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_after busy got=%b want=0", busy);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] got;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            out_port = 8'(16 + i);
            out_we   = 1'b1;
            step();
            if (i == 4) begin
                vectors++;
                if ({full, overflow} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL ovf_full_at_5th full/overflow got=%b want=10", {full, overflow});
                end
            end
            if (i == 5) begin
                vectors++;
                if ({full, overflow} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL ovf_drop full/overflow got=%b want=11", {full, overflow});
                end
            end
        end
        out_we = 1'b0;
        wait_frames(5, 260);
        repeat (60) step();
        vectors++;
        if (frame_q.size() != 5) begin
            miscompares++;
            $display("FAIL ovf_frame_count got=%0d want=5", frame_q.size());
        end
        for (int j = 0; j < 5; j++) begin
            got = (frame_q.size() > j) ? frame_q[j] : 10'bx;
            vectors++;
            if (got !== {1'b1, 8'(16 + j), 1'b0}) begin
                miscompares++;
                $display("FAIL ovf_frame%0d got=%b want=%b", j, got, {1'b1, 8'(16 + j), 1'b0});
            end
        end
        vectors++;
        if ({overflow, empty, full} !== 3'b110) begin
            miscompares++;
            $display("FAIL ovf_sticky overflow/empty/full got=%b want=110", {overflow, empty, full});
        end
    endtask

    task automatic test_full_pop();
        logic [9:0] exp_b [6];
        logic [9:0] got;
        int         s;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            out_port = 8'(8'hA0 + i);
            out_we   = 1'b1;
            step();
        end
        out_we = 1'b0;
        s = (start_q.size() > 0) ? start_q[0] : cyc;
        for (int i = 0; i < 60 && cyc < s + 10 * CPB - 1; i++)
            step();
        vectors++;
        if ({full, overflow, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL fp_before full/overflow/busy got=%b want=101", {full, overflow, busy});
        end
        out_port = 8'hEE;
        out_we   = 1'b1;
        step();
        vectors++;
        if ({overflow, full, empty} !== 3'b100) begin
            miscompares++;
            $display("FAIL fp_drop_on_pop overflow/full/empty got=%b want=100", {overflow, full, empty});
        end
        out_port = 8'hF0;
        step();
        out_we = 1'b0;
        vectors++;
        if (full !== 1'b1) begin
            miscompares++;
            $display("FAIL fp_refill full got=%b want=1", full);
        end
        wait_frames(6, 350);
        repeat (60) step();
        exp_b[0] = {1'b1, 8'hA0, 1'b0};
        exp_b[1] = {1'b1, 8'hA1, 1'b0};
        exp_b[2] = {1'b1, 8'hA2, 1'b0};
        exp_b[3] = {1'b1, 8'hA3, 1'b0};
        exp_b[4] = {1'b1, 8'hA4, 1'b0};
        exp_b[5] = {1'b1, 8'hF0, 1'b0};
        vectors++;
        if (frame_q.size() != 6) begin
            miscompares++;
            $display("FAIL fp_frame_count got=%0d want=6", frame_q.size());
        end
        for (int j = 0; j < 6; j++) begin
            got = (frame_q.size() > j) ? frame_q[j] : 10'bx;
            vectors++;
            if (got !== exp_b[j]) begin
                miscompares++;
                $display("FAIL fp_frame%0d got=%b want=%b", j, got, exp_b[j]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        apply_reset();
        out_we   = 1'b1;
        out_port = 8'hFF;
        step();
        out_port = 8'h00;
        step();
        out_port = 8'h55;
        step();
        out_we = 1'b0;
        s = (start_q.size() > 0) ? start_q[0] : cyc;
        for (int i = 0; i < 40 && cyc < s + 10; i++)
            step();
        #2 rst_n = 1'b1;
        #1;
        vectors++;
        if ({tx, busy, empty, full} !== 4'b1010) begin
            miscompares++;
            $display("FAIL rstmid_data tx/busy/empty/full got=%b want=1010", {tx, busy, empty, full});
        end
        step();
        rst_n = 1'b0;
        frame_q.delete();
        start_q.delete();
        out_port = 8'h00;
        out_we   = 1'b1;
        step();
        out_we = 1'b0;
        step();
        step();
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_start_bit tx got=%b want=0", tx);
        end
        #2 rst_n = 1'b1;
        #1;
        vectors++;
        if ({tx, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_async tx/busy got=%b want=10", {tx, busy});
        end
        step();
        rst_n = 1'b0;
        frame_q.delete();
        start_q.delete();
        for (int i = 0; i < 100; i++) begin
            step();
            vectors++;
            if ({tx, busy, empty} !== 3'b101) begin
                miscompares++;
                $display("FAIL rstmid_quiet cycle %0d tx/busy/empty got=%b want=101", i, {tx, busy, empty});
            end
        end
        vectors++;
        if (start_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_frames got=%0d want=0", start_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
